// File: rtl/led_display_pkg.sv
// ============================================================================
//  Module      : led_display_pkg
//  Description : Shared definitions for the two-digit LED display scanner:
//                converter FSM state encoding, common-anode 7-segment codes
//                (active-low, {dp,g,f,e,d,c,b,a}), digit enable patterns and
//                a digit-to-segment lookup function.
//  Config      : none (LED_ZERO_BLANK_EN is consumed by led_display_scan)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_display_pkg;

    // Converter FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Segment codes, active-low, dp always off
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Digit enables, active-low; bits 7:2 are unused digits held dark
    localparam logic [7:0] LED_EN_OFF   = 8'hFF;
    localparam logic [7:0] LED_EN_UNITS = 8'hFE;
    localparam logic [7:0] LED_EN_TENS  = 8'hFD;

    // BCD digit to segment pattern; non-decimal nibbles render blank
    function automatic logic [7:0] seg_of(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_display_scan_if.sv
// ============================================================================
//  Module      : led_display_scan_if
//  Description : Bundle of the display block's data signals.
//                num     - 7-bit binary value from the counter (0..99 legal)
//                busy    - conversion in flight
//                led_en  - active-low digit enables (bit0 units, bit1 tens)
//                led_seg - active-low segments {dp,g,f,e,d,c,b,a}
//                master drives num; slave (the display block) drives the rest.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_display_scan_if;
    logic [6:0] num;
    logic       busy;
    logic [7:0] led_en;
    logic [7:0] led_seg;

    modport master (
        output num,
        input  busy,
        input  led_en,
        input  led_seg
    );

    modport slave (
        input  num,
        output busy,
        output led_en,
        output led_seg
    );
endinterface

`default_nettype wire

// File: rtl/led_display_scan_bin2bcd.sv
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential shift-add-3 binary to two-digit BCD converter.
//                A new conversion starts whenever the input differs from the
//                last captured value (or none has been captured since reset).
//                Result digits and the out-of-range flag update together.
//  Ports       : clk, rst_n (sync, active-low), bin[6:0] in,
//                busy, tens[3:0], units[3:0], oor out (all registered)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import led_display_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic [6:0] bin,
    output logic            busy,
    output logic [3:0]      tens,
    output logic [3:0]      units,
    output logic            oor
);

    logic [1:0]  r_state;
    logic [14:0] r_sr;          // {tens, units, remaining binary bits}
    logic [2:0]  r_bitcnt;
    logic [6:0]  r_last_num;
    logic        r_last_valid;
    logic        r_busy;
    logic [3:0]  r_tens;
    logic [3:0]  r_units;
    logic        r_oor;

    logic [3:0]  w_tens_adj;
    logic [3:0]  w_units_adj;
    logic [14:0] w_sr_shift;

    // Add-3 correction ahead of the shift; the tens carry into a hundreds
    // digit is dropped, which only matters for values flagged out of range.
    always_comb begin
        w_tens_adj  = (r_sr[14:11] >= 4'd5) ? r_sr[14:11] + 4'd3 : r_sr[14:11];
        w_units_adj = (r_sr[10:7]  >= 4'd5) ? r_sr[10:7]  + 4'd3 : r_sr[10:7];
        w_sr_shift  = {w_tens_adj[2:0], w_units_adj, r_sr[6:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_sr         <= '0;
            r_bitcnt     <= '0;
            r_last_num   <= '0;
            r_last_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_tens       <= '0;
            r_units      <= '0;
            r_oor        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_last_valid || (bin != r_last_num)) begin
                        r_sr         <= {8'd0, bin};
                        r_last_num   <= bin;
                        r_last_valid <= 1'b1;
                        r_bitcnt     <= '0;
                        r_state      <= ST_CONV;
                        r_busy       <= 1'b1;
                    end
                end
                ST_CONV: begin
                    r_sr <= w_sr_shift;
                    if (r_bitcnt == 3'd6) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                end
                ST_DONE: begin
                    r_tens  <= r_sr[14:11];
                    r_units <= r_sr[10:7];
                    r_oor   <= (r_last_num > 7'd99);
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign tens  = r_tens;
    assign units = r_units;
    assign oor   = r_oor;

endmodule

`default_nettype wire

// File: rtl/led_display_scan.sv
// ============================================================================
//  Module      : led_display_scan
//  Description : Two-digit time-multiplexed common-anode 7-segment driver for
//                the 0..99 counter. Converts num to BCD, alternates between
//                the units (led_en bit0) and tens (bit1) digit every SCAN_DIV
//                clocks; out-of-range values show dashes on both digits.
//  Ports       : clk, rst_n (sync, active-low),
//                bus (led_display_scan_if.slave: num in; busy, led_en,
//                led_seg out)
//  Parameters  : SCAN_DIV - clocks per digit slot (>= 2)
//  Config      : LED_ZERO_BLANK_EN - blank the tens digit when it is zero
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_display_scan
    import led_display_pkg::*;
#(
    parameter int SCAN_DIV = 100000
)(
    input  wire logic           clk,
    input  wire logic           rst_n,
    led_display_scan_if.slave   bus
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [3:0]       w_tens;
    logic [3:0]       w_units;
    logic             w_oor;
    logic             w_busy;
    logic [7:0]       w_seg;

    logic [CNT_W-1:0] r_scan_cnt;
    logic             r_sel;        // 0 = units slot, 1 = tens slot
    logic [7:0]       r_led_en;
    logic [7:0]       r_led_seg;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .bin   (bus.num),
        .busy  (w_busy),
        .tens  (w_tens),
        .units (w_units),
        .oor   (w_oor)
    );

    always_comb begin
        w_seg = SEG_BLANK;
        if (w_oor) begin
            w_seg = SEG_DASH;
        end else if (r_sel) begin
`ifdef LED_ZERO_BLANK_EN
            w_seg = (w_tens == 4'd0) ? SEG_BLANK : seg_of(w_tens);
`else
            w_seg = seg_of(w_tens);
`endif
        end else begin
            w_seg = seg_of(w_units);
        end
    end

    // Enable and segment registers load on the same edge from the same
    // slot select so a digit never briefly shows its neighbour's pattern.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_sel      <= 1'b0;
            r_led_en   <= LED_EN_OFF;
            r_led_seg  <= SEG_BLANK;
        end else begin
            if (r_scan_cnt == C_CNT_LAST) begin
                r_scan_cnt <= '0;
                r_sel      <= ~r_sel;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            r_led_en  <= r_sel ? LED_EN_TENS : LED_EN_UNITS;
            r_led_seg <= w_seg;
        end
    end

    assign bus.busy    = w_busy;
    assign bus.led_en  = r_led_en;
    assign bus.led_seg = r_led_seg;

endmodule

`default_nettype wire

// File: tb/tb_led_display_scan.sv
// ============================================================================
//  Module      : tb_led_display_scan
//  Description : Directed self-checking bench for led_display_scan with
//                SCAN_DIV = 4. Edge numbers in comments count rising edges
//                after reset release (edge 1 = first edge with rst_n high).
//  Config      : LED_ZERO_BLANK_EN selects the expected tens pattern for 7
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_display_scan;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   n_fail;

    led_display_scan_if bus ();

    led_display_scan #(.SCAN_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] en, input logic [7:0] seg);
        check({tag, "_en"},  bus.led_en,  en);
        check({tag, "_seg"}, bus.led_seg, seg);
    endtask

    task automatic check_busy(input string tag, input logic exp);
        check(tag, {7'd0, bus.busy}, {7'd0, exp});
    endtask

    // Hold reset for 3 edges with num = v, check reset outputs, release.
    task automatic do_reset(input logic [6:0] v);
        bus.num = v;
        rst_n   = 1'b0;
        tick(3);
        check_out("reset", 8'hFF, 8'hFF);
        check_busy("reset_busy", 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.num  = 7'd0;
        #1;

        // ---- Basic conversion of 42 ----
        do_reset(7'd42);
        tick(1);  check_busy("b42_busy_e1", 1'b1);
        tick(7);  check_busy("b42_busy_e8", 1'b1);
        tick(1);  check_busy("b42_busy_e9", 1'b0);
        tick(1);  check_out("b42_units_e10", 8'hFE, 8'hA4);
        tick(2);  check_out("b42_units_e12", 8'hFE, 8'hA4);
        tick(1);  check_out("b42_tens_e13",  8'hFD, 8'h99);
        tick(3);  check_out("b42_tens_e16",  8'hFD, 8'h99);
        tick(1);  check_out("b42_units_e17", 8'hFE, 8'hA4);

        // ---- num 42 -> 99 during the conversion ----
        do_reset(7'd42);
        tick(3);  bus.num = 7'd99;
        tick(5);  check_busy("mid_busy_e8", 1'b1);
        tick(1);  check_busy("mid_busy_e9", 1'b0);
        tick(1);  check_out("mid_42_e10", 8'hFE, 8'hA4);
                  check_busy("mid_busy2_e10", 1'b1);
        tick(8);  check_out("mid_42_e18", 8'hFE, 8'hA4);
                  check_busy("mid_busy2_e18", 1'b0);
        tick(1);  check_out("mid_99u_e19", 8'hFE, 8'h90);
        tick(2);  check_out("mid_99t_e21", 8'hFD, 8'h90);

        // ---- Out of range 105 ----
        do_reset(7'd105);
        tick(1);  check_busy("oor_busy_e1", 1'b1);
        tick(8);  check_busy("oor_busy_e9", 1'b0);
        tick(1);  check_out("oor_units_e10", 8'hFE, 8'hBF);
        tick(3);  check_out("oor_tens_e13",  8'hFD, 8'hBF);

        // ---- Leading zero, 7 ----
        do_reset(7'd7);
        tick(10); check_out("lz_units_e10", 8'hFE, 8'hF8);
`ifdef LED_ZERO_BLANK_EN
        tick(3);  check_out("lz_tens_e13",  8'hFD, 8'hFF);
`else
        tick(3);  check_out("lz_tens_e13",  8'hFD, 8'hC0);
`endif

        // ---- Reset in the middle of a conversion ----
        do_reset(7'd42);
        tick(4);  check_busy("rmid_busy_e4", 1'b1);
        rst_n   = 1'b0;
        bus.num = 7'd63;
        tick(1);  check_out("rmid_reset", 8'hFF, 8'hFF);
                  check_busy("rmid_reset_busy", 1'b0);
        rst_n = 1'b1;
        tick(1);  check_busy("rmid_busy_e1", 1'b1);
        tick(7);  check_busy("rmid_busy_e8", 1'b1);
        tick(1);  check_busy("rmid_busy_e9", 1'b0);
        tick(1);  check_out("rmid_units_e10", 8'hFE, 8'hB0);
        tick(3);  check_out("rmid_tens_e13",  8'hFD, 8'h82);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
